// File: rtl/keymode_selector_if.sv
// Key-event and control bundle between the PS/2 front end (master) and keymode_selector (slave).
interface keymode_selector_if #(
   parameter int NUM_MODES = 3,
   parameter int NUM_TESTS = 5
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

   logic                 key_event;
   logic [7:0]           scancode;
   logic                 released;
   logic                 extended;
   logic [MW-1:0]        mode;
   logic [NUM_TESTS-1:0] test_pulse;
   logic                 return_to_bios;
   logic                 busy;

   modport master (
      output key_event, scancode, released, extended,
      input  mode, test_pulse, return_to_bios, busy
   );

   modport slave (
      input  key_event, scancode, released, extended,
      output mode, test_pulse, return_to_bios, busy
   );
endinterface

// File: rtl/keymode_selector.sv
// Maps released digit keys to a display mode or a timed one-hot test trigger; Ctrl+Backspace strobes return_to_bios.
// Define KEYMODE_KEYPAD_EN to also accept numeric-keypad digits.
module keymode_selector #(
   parameter int NUM_MODES = 3,
   parameter int NUM_TESTS = 5,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   keymode_selector_if.slave bus
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
   localparam logic [3:0] LP_MODE_MAX   = 4'(NUM_MODES);
   localparam logic [3:0] LP_TEST_MAX   = 4'(NUM_MODES + NUM_TESTS);
   localparam logic [7:0] LP_PULSE_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] LP_GAP_LOAD   = 8'(GAP_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   state_t               r_state, w_state_nxt;
   logic [7:0]           r_cnt, w_cnt_nxt;
   logic [IW-1:0]        r_idx, w_idx_nxt;
   logic [MW-1:0]        r_mode;
   logic                 r_rtb;
   logic                 r_lctrl, r_rctrl;

   logic [3:0]           w_digit;
   logic                 w_rel;
   logic                 w_mode_hit;
   logic                 w_test_hit;
   logic                 w_bs;
   logic [MW-1:0]        w_mode_val;
   logic [IW-1:0]        w_test_idx;
   logic [NUM_TESTS-1:0] w_tp;

   // Digit 1..9 for a scancode, 0 when the code is not a digit key.
   function automatic logic [3:0] f_digit(input logic [7:0] code);
      case (code)
         8'h16:   f_digit = 4'd1;
         8'h1E:   f_digit = 4'd2;
         8'h26:   f_digit = 4'd3;
         8'h25:   f_digit = 4'd4;
         8'h2E:   f_digit = 4'd5;
         8'h36:   f_digit = 4'd6;
         8'h3D:   f_digit = 4'd7;
         8'h3E:   f_digit = 4'd8;
         8'h46:   f_digit = 4'd9;
`ifdef KEYMODE_KEYPAD_EN
         8'h69:   f_digit = 4'd1;
         8'h72:   f_digit = 4'd2;
         8'h7A:   f_digit = 4'd3;
         8'h6B:   f_digit = 4'd4;
         8'h73:   f_digit = 4'd5;
         8'h74:   f_digit = 4'd6;
         8'h6C:   f_digit = 4'd7;
         8'h75:   f_digit = 4'd8;
         8'h7D:   f_digit = 4'd9;
`endif
         default: f_digit = 4'd0;
      endcase
   endfunction

   assign w_digit    = bus.extended ? 4'd0 : f_digit(bus.scancode);
   assign w_rel      = bus.key_event & bus.released & ~bus.extended;
   assign w_mode_hit = w_rel && (w_digit != 4'd0) && (w_digit <= LP_MODE_MAX);
   assign w_test_hit = w_rel && (w_digit > LP_MODE_MAX) && (w_digit <= LP_TEST_MAX);
   assign w_bs       = w_rel && (bus.scancode == 8'h66) && (r_lctrl | r_rctrl);
   assign w_mode_val = MW'(w_digit - 4'd1);
   assign w_test_idx = IW'(w_digit - LP_MODE_MAX - 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // The Ctrl+Backspace strobe aborts any running test and beats a same-cycle trigger.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      if (w_bs) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_test_hit) begin
                  w_state_nxt = S_PULSE;
                  w_idx_nxt   = w_test_idx;
                  w_cnt_nxt   = LP_PULSE_LOAD;
               end
            end
            S_PULSE: begin
               if (r_cnt == 8'd0) begin
                  if (GAP_LEN == 0) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_state_nxt = S_GAP;
                     w_cnt_nxt   = LP_GAP_LOAD;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 8'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == 8'd0) w_state_nxt = S_IDLE;
               else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode  <= '0;
         r_rtb   <= 1'b0;
         r_lctrl <= 1'b0;
         r_rctrl <= 1'b0;
      end else begin
         r_rtb <= w_bs;
         if (w_mode_hit) r_mode <= w_mode_val;
         if (bus.key_event && (bus.scancode == 8'h14)) begin
            if (bus.extended) r_rctrl <= ~bus.released;
            else              r_lctrl <= ~bus.released;
         end
      end
   end

   // Decoded from state so at most one trigger bit can ever be high.
   always_comb begin
      w_tp = '0;
      if (r_state == S_PULSE) begin
         for (int i = 0; i < NUM_TESTS; i++) w_tp[i] = (r_idx == IW'(i));
      end
   end

   assign bus.mode           = r_mode;
   assign bus.test_pulse     = w_tp;
   assign bus.return_to_bios = r_rtb;
   assign bus.busy           = (r_state != S_IDLE);
endmodule
